uart_ld_fifo: RTL and testbench

//  Parametrised successor to the single-entry load register. Buffers DEPTH words of

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_fifo_ptr.sv | 40 ++++
 rtl/uart_ld_fifo.sv | 138 +++++++++++++
 tb/tb_uart_ld_fifo.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: default FIFO geometry and the status bundle that
// the receive FIFO exports to the UART status register.
package uart_pkg;

    localparam int UART_DATA_W     = 8;
    localparam int UART_FIFO_DEPTH = 4;

    // Status bundle as it appears in the UART status register.
    typedef struct packed {
        logic ovr;    // sticky: load dropped while full
        logic udr;    // sticky: read issued while empty
        logic full;   // DEPTH entries held
        logic empty;  // no entries held
    } uart_fifo_status_t;

endpackage : uart_pkg

// File: rtl/uart_fifo_ptr.sv
// AW-bit wrapping pointer for the receive FIFO. The pointer advances by one
// when inc_i is high and wraps DEPTH-1 -> 0 by natural overflow, since DEPTH
// is a power of two. A synchronous clear has priority over the increment.
module uart_fifo_ptr #(
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [AW-1:0] ptr_o
);

    logic [AW-1:0] ptr_q;
    logic [AW-1:0] ptr_d;

    // Next pointer: clear wins, otherwise step by one on inc.
    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = ptr_q + AW'(1);
        end
    end

    // Pointer register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop
            // samples pre-edge values regardless of block evaluation order.
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule : uart_fifo_ptr

// File: rtl/uart_ld_fifo.sv
// Receive-side FIFO between the UART shifter and the host read port.
// First-word-fall-through: the head entry is always presented on Q (0 when
// empty). Sticky ovr/udr flags record dropped loads and reads while empty.
// Every output is taken from registers; there is no input-to-output path.
module uart_ld_fifo
    import uart_pkg::*;
#(
    parameter  int WIDTH = UART_DATA_W,
    parameter  int DEPTH = UART_FIFO_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] D,
    input  logic             rd,
    output logic [WIDTH-1:0] Q,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count,
    output logic             ovr,
    output logic             udr,
    input  logic             err_clr
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [AW:0]       count_q;
    logic [AW:0]       count_d;
    logic              ovr_q;
    logic              ovr_d;
    logic              udr_q;
    logic              udr_d;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              is_empty;
    logic              is_full;
    logic              wr_en;
    logic              rd_en;
    logic              ovr_set;
    logic              udr_set;
    uart_fifo_status_t status;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == FULL_CNT);

    // Accept/pop decisions for this edge. A flush suppresses both. A load is
    // taken unless the FIFO is full with no pop making room; when empty a
    // simultaneous rd is not honoured but the load still goes in.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        ovr_set = 1'b0;
        udr_set = 1'b0;
        if (!clr) begin
            wr_en   = load & (!is_full | rd);
            rd_en   = rd & !is_empty;
            ovr_set = load & !rd & is_full;
            udr_set = rd & is_empty;
        end
    end

    // Occupancy and sticky-flag next state; a new error beats err_clr.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else begin
            unique case ({wr_en, rd_en})
                2'b10:   count_d = count_q + (AW + 1)'(1);
                2'b01:   count_d = count_q - (AW + 1)'(1);
                default: count_d = count_q;
            endcase
        end
        ovr_d = (ovr_q & !err_clr) | ovr_set;
        udr_d = (udr_q & !err_clr) | udr_set;
    end

    // Occupancy counter and sticky error flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            ovr_q   <= 1'b0;
            udr_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovr_q   <= ovr_d;
            udr_q   <= udr_d;
        end
    end

    // Entry storage: write the tail on an accepted load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: storage is cleared on reset so no stale or partially written
            // frame survives; affordable because the array is a handful of flops.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_ptr] <= D;
        end
    end

    uart_fifo_ptr #(
        .AW (AW)
    ) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst),
        .clr_i (clr),
        .inc_i (wr_en),
        .ptr_o (wr_ptr)
    );

    uart_fifo_ptr #(
        .AW (AW)
    ) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst),
        .clr_i (clr),
        .inc_i (rd_en),
        .ptr_o (rd_ptr)
    );

    assign status = '{ovr: ovr_q, udr: udr_q, full: is_full, empty: is_empty};

    assign Q     = status.empty ? '0 : mem_q[rd_ptr];
    assign empty = status.empty;
    assign full  = status.full;
    assign ovr   = status.ovr;
    assign udr   = status.udr;
    assign count = count_q;

endmodule : uart_ld_fifo

// File: tb/tb_uart_ld_fifo.sv
// Self-checking bench for uart_ld_fifo (WIDTH=8, DEPTH=4): directed vector
// table, hand-written reset/wrap/flush sequences, then random traffic against
// a queue-based reference model.
module tb_uart_ld_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] D;
    logic             rd;
    logic [WIDTH-1:0] Q;
    logic             empty;
    logic             full;
    logic [AW:0]      count;
    logic             ovr;
    logic             udr;
    logic             err_clr;

    int checks = 0;
    int errors = 0;

    // Reference model: the FIFO contents as a queue plus the two sticky flags.
    logic [WIDTH-1:0] mq [$];
    bit               m_ovr;
    bit               m_udr;

    typedef struct {
        bit               l;
        bit               r;
        bit               c;
        bit               e;
        logic [WIDTH-1:0] d;
        int               cnt;
        logic [WIDTH-1:0] q;
        bit               o;
        bit               u;
    } vec_t;

    vec_t tbl [$];

    uart_ld_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .load    (load),
        .D       (D),
        .rd      (rd),
        .Q       (Q),
        .empty   (empty),
        .full    (full),
        .count   (count),
        .ovr     (ovr),
        .udr     (udr),
        .err_clr (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t v(bit l, bit r, bit c, bit e, logic [WIDTH-1:0] d,
                               int cnt, logic [WIDTH-1:0] q, bit o, bit u);
        vec_t x;
        x.l = l; x.r = r; x.c = c; x.e = e; x.d = d;
        x.cnt = cnt; x.q = q; x.o = o; x.u = u;
        return x;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ovr = 1'b0;
        m_udr = 1'b0;
    endtask

    // Drive one cycle of inputs, clock it, sample 1 ns after the edge and
    // advance the reference model by the same edge.
    task automatic cycle(input bit l, input bit r, input bit c, input bit e,
                         input logic [WIDTH-1:0] d);
        bit so;
        bit su;
        load = l; rd = r; clr = c; err_clr = e; D = d;
        @(posedge clk);
        #1;
        so = 1'b0;
        su = 1'b0;
        if (c) begin
            mq.delete();
        end else begin
            so = l && !r && (mq.size() == DEPTH);
            su = r && (mq.size() == 0);
            if (r && mq.size() > 0) void'(mq.pop_front());
            if (l && mq.size() < DEPTH) mq.push_back(d);
        end
        m_ovr = (m_ovr && !e) || so;
        m_udr = (m_udr && !e) || su;
        load = 1'b0; rd = 1'b0; clr = 1'b0; err_clr = 1'b0;
    endtask

    task automatic check_model(input string tag);
        logic [WIDTH-1:0] hq;
        hq = (mq.size() > 0) ? mq[0] : '0;
        check({tag, " count"}, 32'(count), 32'(mq.size()));
        check({tag, " Q"}, 32'(Q), 32'(hq));
        check({tag, " empty"}, 32'(empty), 32'(mq.size() == 0));
        check({tag, " full"}, 32'(full), 32'(mq.size() == DEPTH));
        check({tag, " ovr"}, 32'(ovr), 32'(m_ovr));
        check({tag, " udr"}, 32'(udr), 32'(m_udr));
    endtask

    initial begin
        rst = 1'b0; clr = 1'b0; load = 1'b0; rd = 1'b0; err_clr = 1'b0; D = '0;
        model_reset();

        // Reset state
        #12;
        check("rst count", 32'(count), 32'd0);
        check("rst empty", 32'(empty), 32'd1);
        check("rst full", 32'(full), 32'd0);
        check("rst Q", 32'(Q), 32'd0);
        check("rst ovr", 32'(ovr), 32'd0);
        check("rst udr", 32'(udr), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors: {load, rd, clr, err_clr, D} -> {count, Q, ovr, udr}
        // fill / drain
        tbl.push_back(v(1, 0, 0, 0, 8'hA1, 1, 8'hA1, 0, 0));
        tbl.push_back(v(1, 0, 0, 0, 8'hB2, 2, 8'hA1, 0, 0));
        tbl.push_back(v(1, 0, 0, 0, 8'hC3, 3, 8'hA1, 0, 0));
        tbl.push_back(v(1, 0, 0, 0, 8'hD4, 4, 8'hA1, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 8'h00, 3, 8'hB2, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 8'h00, 2, 8'hC3, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 8'h00, 1, 8'hD4, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0));
        // underrun, then load+rd on empty
        tbl.push_back(v(0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 1));
        tbl.push_back(v(1, 1, 0, 0, 8'h55, 1, 8'h55, 0, 1));
        tbl.push_back(v(0, 0, 0, 1, 8'h00, 1, 8'h55, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0));
        // overrun, set-beats-clear, then clear
        tbl.push_back(v(1, 0, 0, 0, 8'h11, 1, 8'h11, 0, 0));
        tbl.push_back(v(1, 0, 0, 0, 8'h22, 2, 8'h11, 0, 0));
        tbl.push_back(v(1, 0, 0, 0, 8'h33, 3, 8'h11, 0, 0));
        tbl.push_back(v(1, 0, 0, 0, 8'h44, 4, 8'h11, 0, 0));
        tbl.push_back(v(1, 0, 0, 0, 8'hEE, 4, 8'h11, 1, 0));
        tbl.push_back(v(1, 0, 0, 1, 8'hEE, 4, 8'h11, 1, 0));
        tbl.push_back(v(0, 0, 0, 1, 8'h00, 4, 8'h11, 0, 0));
        // push while popping when full, 0x77 comes out last
        tbl.push_back(v(1, 1, 0, 0, 8'h77, 4, 8'h22, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 8'h00, 3, 8'h33, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 8'h00, 2, 8'h44, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 8'h00, 1, 8'h77, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0));
        // flush beats a simultaneous load
        tbl.push_back(v(1, 0, 0, 0, 8'h01, 1, 8'h01, 0, 0));
        tbl.push_back(v(1, 0, 0, 0, 8'h02, 2, 8'h01, 0, 0));
        tbl.push_back(v(1, 0, 1, 0, 8'h03, 0, 8'h00, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].l, tbl[i].r, tbl[i].c, tbl[i].e, tbl[i].d);
            check($sformatf("vec%0d count", i), 32'(count), 32'(tbl[i].cnt));
            check($sformatf("vec%0d Q", i), 32'(Q), 32'(tbl[i].q));
            check($sformatf("vec%0d empty", i), 32'(empty), 32'(tbl[i].cnt == 0));
            check($sformatf("vec%0d full", i), 32'(full), 32'(tbl[i].cnt == DEPTH));
            check($sformatf("vec%0d ovr", i), 32'(ovr), 32'(tbl[i].o));
            check($sformatf("vec%0d udr", i), 32'(udr), 32'(tbl[i].u));
        end

        // Asynchronous reset mid-stream with count=3 and both flags set
        cycle(0, 1, 0, 0, 8'h00);
        for (int i = 0; i < DEPTH; i++) cycle(1, 0, 0, 0, 8'(8'h60 + i));
        cycle(1, 0, 0, 0, 8'hEE);
        cycle(0, 1, 0, 0, 8'h00);
        check_model("pre-rst");
        #2;
        rst = 1'b0;
        #1;
        check("midrst count", 32'(count), 32'd0);
        check("midrst empty", 32'(empty), 32'd1);
        check("midrst Q", 32'(Q), 32'd0);
        check("midrst ovr", 32'(ovr), 32'd0);
        check("midrst udr", 32'(udr), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Pointer wrap: 10 load/rd pairs with two entries in flight
        cycle(1, 0, 0, 0, 8'($urandom));
        cycle(1, 0, 0, 0, 8'($urandom));
        for (int i = 0; i < 10; i++) begin
            cycle(1, 1, 0, 0, 8'($urandom));
            check_model($sformatf("wrap%0d", i));
        end
        cycle(1, 0, 1, 0, 8'h99);
        check("flush count", 32'(count), 32'd0);
        check("flush empty", 32'(empty), 32'd1);
        check("flush Q", 32'(Q), 32'd0);
        cycle(0, 0, 0, 0, 8'h00);
        check_model("post-flush");

        // Random traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            cycle(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                  ($urandom_range(0, 31) == 0), ($urandom_range(0, 7) == 0),
                  8'($urandom));
            check_model($sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_uart_ld_fifo
